// File: rtl/spart_driver.sv
// SPART host-side driver: programs the baud divisor, then polls status and
// moves bytes between the SPART and a 4-deep TX FIFO, optionally echoing RX.
module spart_driver #(
    parameter logic [15:0] DIV_4800  = 16'h0516,
    parameter logic [15:0] DIV_9600  = 16'h028B,
    parameter logic [15:0] DIV_19200 = 16'h0145,
    parameter logic [15:0] DIV_38400 = 16'h00A2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] br_cfg,
    input  logic       echo_en,
    input  logic       tx_wr,
    input  logic [7:0] tx_data,
    output logic       tx_full,
    output logic       rx_valid,
    output logic [7:0] rx_byte,
    output logic       cfg_done,
    output logic       iocs,
    output logic       iorw,
    output logic [1:0] ioaddr,
    output logic [7:0] databus_out,
    input  logic [7:0] databus_in
);

    typedef enum logic [2:0] {
        INIT, CFG_LO, CFG_HI, POLL, READ_RX, WRITE_TX
    } state_t;

    state_t      state_q;
    logic [1:0]  cfg_q;
    logic        cfg_done_q;
    logic        rx_valid_q;
    logic [7:0]  rx_byte_q;
    logic [7:0]  mem_q [4];
    logic [1:0]  wr_ptr_q;
    logic [1:0]  rd_ptr_q;
    logic [2:0]  cnt_q;
    logic [2:0]  cnt_d;
    logic [15:0] div;
    logic        full;
    logic        empty;
    logic        push;
    logic        pop;
    logic        push_ok;
    logic [7:0]  push_data;

    assign full      = (cnt_q == 3'd4);
    assign empty     = (cnt_q == 3'd0);
    assign push      = echo_en ? (state_q == READ_RX) : tx_wr;
    assign push_data = echo_en ? databus_in : tx_data;
    assign pop       = (state_q == WRITE_TX) && !empty;
    // a pop in the same cycle frees the slot, so a push while full still lands
    assign push_ok   = push && (!full || pop);

    assign tx_full  = full;
    assign rx_valid = rx_valid_q;
    assign rx_byte  = rx_byte_q;
    assign cfg_done = cfg_done_q;

    always_comb begin
        unique case (cfg_q)
            2'b00: div = DIV_4800;
            2'b01: div = DIV_9600;
            2'b10: div = DIV_19200;
            2'b11: div = DIV_38400;
        endcase
    end

    always_comb begin
        iocs        = 1'b0;
        iorw        = 1'b1;
        ioaddr      = 2'b00;
        databus_out = 8'h00;
        case (state_q)
            CFG_LO: begin
                iocs        = 1'b1;
                iorw        = 1'b0;
                ioaddr      = 2'b10;
                databus_out = div[7:0];
            end
            CFG_HI: begin
                iocs        = 1'b1;
                iorw        = 1'b0;
                ioaddr      = 2'b11;
                databus_out = div[15:8];
            end
            POLL: begin
                iocs   = 1'b1;
                ioaddr = 2'b01;
            end
            READ_RX: begin
                iocs = 1'b1;
            end
            WRITE_TX: begin
                iocs        = 1'b1;
                iorw        = 1'b0;
                databus_out = mem_q[rd_ptr_q];
            end
            default: ;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if (push_ok && !pop) begin
            cnt_d = cnt_q + 3'd1;
        end else if (pop && !push_ok) begin
            cnt_d = cnt_q - 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= 2'd0;
            rd_ptr_q <= 2'd0;
            cnt_q    <= 3'd0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= wr_ptr_q + 2'd1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 2'd1;
            end
            cnt_q <= cnt_d;
        end
    end

    // cfg_q is captured on entry to CFG_LO so the divisor bytes match it
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= INIT;
            cfg_q      <= 2'b00;
            cfg_done_q <= 1'b0;
            rx_valid_q <= 1'b0;
            rx_byte_q  <= 8'h00;
        end else begin
            rx_valid_q <= 1'b0;
            case (state_q)
                INIT: begin
                    cfg_q      <= br_cfg;
                    cfg_done_q <= 1'b0;
                    state_q    <= CFG_LO;
                end
                CFG_LO: state_q <= CFG_HI;
                CFG_HI: begin
                    cfg_done_q <= 1'b1;
                    state_q    <= POLL;
                end
                POLL: begin
                    if (br_cfg != cfg_q) begin
                        cfg_q      <= br_cfg;
                        cfg_done_q <= 1'b0;
                        state_q    <= CFG_LO;
                    end else if (databus_in[0] && !(echo_en && full)) begin
                        state_q <= READ_RX;
                    end else if (databus_in[1] && !empty) begin
                        state_q <= WRITE_TX;
                    end
                end
                READ_RX: begin
                    rx_byte_q  <= databus_in;
                    rx_valid_q <= 1'b1;
                    state_q    <= POLL;
                end
                WRITE_TX: state_q <= POLL;
                default:  state_q <= INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_spart_driver.sv
// Bench for spart_driver: directed bring-up/echo/FIFO/reconfig/reset steps,
// then randomized traffic checked against a queue-based transaction model.
module tb_spart_driver;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] br_cfg;
    logic       echo_en;
    logic       tx_wr;
    logic [7:0] tx_data;
    logic       tx_full;
    logic       rx_valid;
    logic [7:0] rx_byte;
    logic       cfg_done;
    logic       iocs;
    logic       iorw;
    logic [1:0] ioaddr;
    logic [7:0] databus_out;
    logic [7:0] databus_in;

    logic [7:0] status_v;
    logic [7:0] rx_v;

    int n_vec = 0;
    int n_err = 0;

    localparam int K_OTHER = 0;
    localparam int K_POLL  = 1;
    localparam int K_RD    = 2;
    localparam int K_WR    = 3;

    logic [7:0] mq [$];

    spart_driver dut (
        .clk         (clk),
        .rst         (rst),
        .br_cfg      (br_cfg),
        .echo_en     (echo_en),
        .tx_wr       (tx_wr),
        .tx_data     (tx_data),
        .tx_full     (tx_full),
        .rx_valid    (rx_valid),
        .rx_byte     (rx_byte),
        .cfg_done    (cfg_done),
        .iocs        (iocs),
        .iorw        (iorw),
        .ioaddr      (ioaddr),
        .databus_out (databus_out),
        .databus_in  (databus_in)
    );

    always #5 clk = ~clk;

    // SPART slave: status register at 01, RX data register at 00
    assign databus_in = (ioaddr == 2'b01) ? status_v : rx_v;

    function automatic int kind();
        if (iocs && iorw && ioaddr == 2'b01) return K_POLL;
        if (iocs && iorw && ioaddr == 2'b00) return K_RD;
        if (iocs && !iorw && ioaddr == 2'b00) return K_WR;
        return K_OTHER;
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic push_bytes(input logic [7:0] first, input int n);
        for (int i = 0; i < n; i++) begin
            tx_wr   = 1'b1;
            tx_data = first + 8'(i);
            tick();
        end
        tx_wr = 1'b0;
    endtask

    task automatic drain();
        logic ok;
        ok = 1'b0;
        status_v = 8'h02;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (kind() == K_WR) begin
                if (mq.size() == 0) begin
                    chk("drain_extra_write", 16'd1, 16'd0);
                end else begin
                    chk("drain_data", {8'h00, databus_out}, {8'h00, mq[0]});
                    void'(mq.pop_front());
                end
            end
            if (mq.size() == 0 && kind() == K_POLL) begin
                ok = 1'b1;
                break;
            end
        end
        chk("drain_done", {15'd0, ok}, 16'd1);
        chk("drain_tx_full", {15'd0, tx_full}, 16'd0);
        status_v = 8'h00;
    endtask

    initial begin
        int         pk;
        int         ek;
        int         psz;
        logic       pwr;
        logic [7:0] pdat;
        logic [7:0] ps;
        logic [7:0] prx;

        rst      = 1'b1;
        br_cfg   = 2'b01;
        echo_en  = 1'b0;
        tx_wr    = 1'b0;
        tx_data  = 8'h00;
        status_v = 8'h00;
        rx_v     = 8'h00;

        // reset and bring-up at 9600
        tick();
        tick();
        chk("rst_iocs", {15'd0, iocs}, 16'd0);
        chk("rst_iorw", {15'd0, iorw}, 16'd1);
        chk("rst_ioaddr", {14'd0, ioaddr}, 16'd0);
        chk("rst_dout", {8'h00, databus_out}, 16'h00);
        chk("rst_cfg_done", {15'd0, cfg_done}, 16'd0);
        chk("rst_rx_valid", {15'd0, rx_valid}, 16'd0);
        chk("rst_rx_byte", {8'h00, rx_byte}, 16'h00);
        chk("rst_tx_full", {15'd0, tx_full}, 16'd0);
        rst = 1'b0;
        tick();
        chk("cfglo_addr", {14'd0, ioaddr, iocs, iorw}, {14'd2, 2'b10});
        chk("cfglo_data", {8'h00, databus_out}, 16'h8B);
        chk("cfglo_done", {15'd0, cfg_done}, 16'd0);
        tick();
        chk("cfghi_addr", {14'd0, ioaddr, iocs, iorw}, {14'd3, 2'b10});
        chk("cfghi_data", {8'h00, databus_out}, 16'h02);
        tick();
        chk("poll_kind", 16'(kind()), 16'(K_POLL));
        chk("poll_done", {15'd0, cfg_done}, 16'd1);

        // echo path
        echo_en  = 1'b1;
        status_v = 8'h01;
        rx_v     = 8'hA5;
        tick();
        chk("echo_rd", 16'(kind()), 16'(K_RD));
        status_v = 8'h02;
        tick();
        chk("echo_rx_valid", {15'd0, rx_valid}, 16'd1);
        chk("echo_rx_byte", {8'h00, rx_byte}, 16'hA5);
        chk("echo_poll", 16'(kind()), 16'(K_POLL));
        tick();
        chk("echo_wr", 16'(kind()), 16'(K_WR));
        chk("echo_wr_data", {8'h00, databus_out}, 16'hA5);
        chk("echo_rx_pulse", {15'd0, rx_valid}, 16'd0);
        status_v = 8'h00;
        tick();
        chk("echo_empty", {15'd0, tx_full}, 16'd0);
        status_v = 8'h02;
        tick();
        chk("echo_no_wr", 16'(kind()), 16'(K_POLL));
        status_v = 8'h00;

        // RX has priority over TX
        echo_en = 1'b0;
        push_bytes(8'h3C, 1);
        status_v = 8'h03;
        rx_v     = 8'h5A;
        tick();
        chk("prio_rd", 16'(kind()), 16'(K_RD));
        status_v = 8'h02;
        tick();
        chk("prio_rx_byte", {8'h00, rx_byte}, 16'h5A);
        tick();
        chk("prio_wr", 16'(kind()), 16'(K_WR));
        chk("prio_wr_data", {8'h00, databus_out}, 16'h3C);
        status_v = 8'h00;
        tick();

        // full FIFO, fifth push dropped
        push_bytes(8'h11, 5);
        chk("full_flag", {15'd0, tx_full}, 16'd1);
        status_v = 8'h02;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("full_wr", 16'(kind()), 16'(K_WR));
            chk("full_data", {8'h00, databus_out}, 16'(8'h11 + k));
            tick();
            chk("full_poll", 16'(kind()), 16'(K_POLL));
        end
        chk("full_drained", {15'd0, tx_full}, 16'd0);
        tick();
        chk("full_dropped", 16'(kind()), 16'(K_POLL));
        status_v = 8'h00;

        // echo stall while full
        push_bytes(8'h21, 4);
        echo_en  = 1'b1;
        status_v = 8'h01;
        rx_v     = 8'h77;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("stall_poll", 16'(kind()), 16'(K_POLL));
        end
        status_v = 8'h02;
        tick();
        chk("stall_wr", {8'h00, databus_out}, 16'h21);
        status_v = 8'h01;
        tick();
        tick();
        chk("stall_rd", 16'(kind()), 16'(K_RD));
        status_v = 8'h00;
        tick();
        chk("stall_refull", {15'd0, tx_full}, 16'd1);
        mq = '{8'h22, 8'h23, 8'h24, 8'h77};
        drain();

        // baud change mid-READ_RX
        echo_en  = 1'b0;
        status_v = 8'h01;
        rx_v     = 8'h99;
        tick();
        chk("recfg_rd", 16'(kind()), 16'(K_RD));
        br_cfg   = 2'b11;
        status_v = 8'h00;
        tick();
        chk("recfg_poll", 16'(kind()), 16'(K_POLL));
        chk("recfg_rx", {7'd0, rx_valid, rx_byte}, 16'h0199);
        tick();
        chk("recfg_lo", {6'd0, ioaddr, databus_out}, 16'h2A2);
        chk("recfg_done0", {15'd0, cfg_done}, 16'd0);
        tick();
        chk("recfg_hi", {6'd0, ioaddr, databus_out}, 16'h300);
        tick();
        chk("recfg_done1", {15'd0, cfg_done}, 16'd1);

        // reset in the middle of WRITE_TX
        push_bytes(8'h31, 2);
        status_v = 8'h02;
        tick();
        chk("rstwr_wr", 16'(kind()), 16'(K_WR));
        rst = 1'b1;
        tick();
        chk("rstwr_iocs", {15'd0, iocs}, 16'd0);
        chk("rstwr_full", {15'd0, tx_full}, 16'd0);
        chk("rstwr_done", {15'd0, cfg_done}, 16'd0);
        rst = 1'b0;
        tick();
        chk("rstwr_lo", {6'd0, ioaddr, databus_out}, 16'h2A2);
        tick();
        tick();
        tick();
        chk("rstwr_empty", 16'(kind()), 16'(K_POLL));
        status_v = 8'h00;
        mq.delete();

        // randomized traffic against the transaction model
        for (int seg = 0; seg < 2; seg++) begin
            echo_en = (seg == 1);
            for (int n = 0; n < 300; n++) begin
                tx_wr    = 1'($urandom);
                tx_data  = 8'($urandom);
                status_v = {6'd0, 2'($urandom)};
                rx_v     = 8'($urandom);
                pk   = kind();
                pwr  = tx_wr;
                pdat = tx_data;
                ps   = status_v;
                prx  = rx_v;
                psz  = mq.size();
                if (pk == K_WR) begin
                    if (mq.size() == 0) begin
                        chk("rnd_wr_empty", 16'd1, 16'd0);
                    end else begin
                        chk("rnd_wr_data", {8'h00, databus_out},
                            {8'h00, mq[0]});
                        void'(mq.pop_front());
                    end
                end
                tick();
                if (echo_en ? (pk == K_RD) : pwr) begin
                    if (mq.size() < 4) mq.push_back(echo_en ? prx : pdat);
                end
                ek = K_POLL;
                if (pk == K_POLL) begin
                    if (ps[0] && !(echo_en && psz == 4)) ek = K_RD;
                    else if (ps[1] && psz != 0) ek = K_WR;
                end
                chk("rnd_kind", 16'(kind()), 16'(ek));
                chk("rnd_full", {15'd0, tx_full}, 16'(mq.size() == 4));
                chk("rnd_rx_valid", {15'd0, rx_valid}, 16'(pk == K_RD));
                if (pk == K_RD) begin
                    chk("rnd_rx_byte", {8'h00, rx_byte}, {8'h00, prx});
                end
            end
        end
        tx_wr = 1'b0;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
